// File: rtl/mips_multicycle_cu_if.sv
// Control-unit <-> datapath bundle. The IR fields, the ALU zero flag and the
// memory handshake come in from the datapath. Mux selects and enables go out.
interface mips_multicycle_cu_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] ALUOp;
    logic [1:0] pcSrc;
    logic [3:0] state;
    logic       illegal;
    logic       memError;

    // Control unit side
    modport master (
        input  opcode, func, zero, memReady,
        output pcWrite, IorD, memRead, memWrite, irWrite, regWrite, regDst,
               memToReg, aluSrcA, aluSrcB, ALUOp, pcSrc, state, illegal, memError
    );

    // Datapath side
    modport slave (
        output opcode, func, zero, memReady,
        input  pcWrite, IorD, memRead, memWrite, irWrite, regWrite, regDst,
               memToReg, aluSrcA, aluSrcB, ALUOp, pcSrc, state, illegal, memError
    );
endinterface

// File: rtl/mips_multicycle_cu.sv
// Multicycle MIPS control unit: a Moore FSM that sequences a shared-memory
// datapath. Memory states stall on memReady and abort after MEM_TIMEOUT
// wait cycles. A value of 0 for MEM_TIMEOUT disables the abort.
module mips_multicycle_cu #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst,   // asynchronous, active-low
    mips_multicycle_cu_if.master         bus
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(MEM_TIMEOUT);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JR     = 4'd12;
    localparam logic [3:0] S_LUI    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_state;
    logic          timeout;
    logic          illegal_op;

    // Memory-state classification and timeout detection
    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.memReady && (wait_q == TO_LIMIT);
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        // Any exit from a memory state (or abort back to FETCH) clears the counter.
        wait_d     = '0;
        if (mem_state && !bus.memReady && !timeout && (MEM_TIMEOUT != 0))
            wait_d = wait_q + 1'b1;
        case (state_q)
            S_FETCH:  if (bus.memReady) state_d = S_DECODE;
                      else if (timeout) state_d = S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:       state_d = (bus.func == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_LUI:         state_d = S_LUI;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.memReady) state_d = S_MEMWB;
                      else if (timeout) state_d = S_FETCH;
            S_MEMWR:  if (bus.memReady || timeout) state_d = S_FETCH;
            S_EXEC:   state_d = ((bus.func == FN_MULT) || (bus.func == FN_DIV)) ? S_FETCH : S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;  // single-cycle states and unreachable 14/15
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Moore control outputs, forced low while reset is asserted
    always_comb begin
        bus.pcWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.irWrite  = 1'b0;
        bus.regWrite = 1'b0;
        bus.regDst   = 2'b00;
        bus.memToReg = 2'b00;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.pcSrc    = 2'b00;
        bus.state    = 4'd0;
        bus.illegal  = 1'b0;
        bus.memError = 1'b0;
        if (rst) begin
            bus.state    = state_q;
            bus.memError = timeout;
            case (state_q)
                S_FETCH: begin
                    bus.memRead = 1'b1;
                    bus.aluSrcB = 2'b01;
                    bus.irWrite = bus.memReady;
                    bus.pcWrite = bus.memReady;
                end
                S_DECODE: begin
                    bus.aluSrcB = 2'b11;  // branch target into ALUOut
                    bus.illegal = illegal_op;
                end
                S_MEMADR: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.memRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regWrite = 1'b1;
                    bus.memToReg = 2'b01;
                end
                S_MEMWR: begin
                    bus.memWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC: begin
                    bus.aluSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_RWB: begin
                    bus.regWrite = 1'b1;
                    bus.regDst   = 2'b01;
                end
                S_IEXEC: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                    bus.ALUOp   = (bus.opcode == OP_SLTI) ? 2'b11 : 2'b00;
                end
                S_IWB: bus.regWrite = 1'b1;
                S_BRANCH: begin
                    bus.aluSrcA = 1'b1;
                    bus.ALUOp   = 2'b01;
                    bus.pcSrc   = 2'b01;
                    bus.pcWrite = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
                end
                S_JUMP: begin
                    bus.pcSrc   = 2'b10;
                    bus.pcWrite = 1'b1;
                    if (bus.opcode == OP_JAL) begin
                        bus.regWrite = 1'b1;  // PC already holds PC+4
                        bus.regDst   = 2'b10;
                        bus.memToReg = 2'b11;
                    end
                end
                S_JR: begin
                    bus.pcSrc   = 2'b11;
                    bus.pcWrite = 1'b1;
                end
                S_LUI: begin
                    bus.regWrite = 1'b1;
                    bus.memToReg = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_cu.sv
// Self-checking bench for mips_multicycle_cu. For each instruction the
// reference model expands the instruction class into the expected list of
// (state, memReady, memError) cycles. It then checks the full control word
// every cycle against the control table.
module tb_mips_multicycle_cu;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mips_multicycle_cu_if bus();

    mips_multicycle_cu #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // expected cycle list for the current instruction
    int q_st[$];
    bit q_rdy[$];
    bit q_err[$];
    bit q_mem[$];

    function automatic logic [22:0] exp_ctrl(int st, logic [5:0] op, logic z, logic rdy, logic err);
        logic pw, iod, mr, mw, irw, rw, asa, ill;
        logic [1:0] rd, m2r, asb, aop, ps;
        {pw, iod, mr, mw, irw, rw, asa, ill} = '0;
        {rd, m2r, asb, aop, ps} = '0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  begin asb = 2'b11; ill = !(op inside {6'd0, 6'd35, 6'd43, 6'd8, 6'd10, 6'd15, 6'd4, 6'd5, 6'd2, 6'd3}); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; asb = 2'b10; aop = (op == 6'd10) ? 2'b11 : 2'b00; end
            9:  rw = 1;
            10: begin asa = 1; aop = 2'b01; ps = 2'b01; pw = (op == 6'd5) ? !z : z; end
            11: begin ps = 2'b10; pw = 1; if (op == 6'd3) begin rw = 1; rd = 2'b10; m2r = 2'b11; end end
            12: begin ps = 2'b11; pw = 1; end
            13: begin rw = 1; m2r = 2'b10; end
            default: ;
        endcase
        return {pw, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ps, 4'(st), ill, err};
    endfunction

    function automatic logic [22:0] obs_word();
        return {bus.pcWrite, bus.IorD, bus.memRead, bus.memWrite, bus.irWrite, bus.regWrite,
                bus.regDst, bus.memToReg, bus.aluSrcA, bus.aluSrcB, bus.ALUOp, bus.pcSrc,
                bus.state, bus.illegal, bus.memError};
    endfunction

    task automatic check_word(string tag, logic [22:0] exp);
        logic [22:0] obs;
        obs = obs_word();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_fixed(int st);
        q_st.push_back(st); q_rdy.push_back(1'b0); q_err.push_back(1'b0); q_mem.push_back(1'b0);
    endtask

    // memory state: 'waits' not-ready cycles, unless the timeout limit is hit first
    task automatic add_wait(int st, int waits, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            q_st.push_back(st); q_mem.push_back(1'b1);
            if (k == waits) begin
                q_rdy.push_back(1'b1); q_err.push_back(1'b0); ok = 1'b1; break;
            end
            q_rdy.push_back(1'b0);
            if (k == TO) begin
                q_err.push_back(1'b1); break;
            end
            q_err.push_back(1'b0);
        end
    endtask

    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
        bit ok;
        logic rdy;
        q_st.delete(); q_rdy.delete(); q_err.delete(); q_mem.delete();
        add_wait(0, fw, ok);
        if (ok) begin
            add_fixed(1);
            case (op)
                6'd0: begin
                    if (fn == 6'd8) add_fixed(12);
                    else begin
                        add_fixed(6);
                        if (!(fn inside {6'd24, 6'd26})) add_fixed(7);
                    end
                end
                6'd35: begin add_fixed(2); add_wait(3, mw, ok); if (ok) add_fixed(4); end
                6'd43: begin add_fixed(2); add_wait(5, mw, ok); end
                6'd8, 6'd10: begin add_fixed(8); add_fixed(9); end
                6'd15: add_fixed(13);
                6'd4, 6'd5: add_fixed(10);
                6'd2, 6'd3: add_fixed(11);
                default: ;
            endcase
        end
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            bus.opcode = op;
            bus.func   = fn;
            bus.zero   = z;
            rdy        = q_mem[i] ? q_rdy[i] : 1'($urandom_range(0, 1));
            bus.memReady = rdy;
            #1;
            check_word($sformatf("op=%0d fn=%0d st=%0d cyc=%0d", op, fn, q_st[i], i),
                       exp_ctrl(q_st[i], op, z, rdy, q_err[i]));
        end
        $display("instr op=%0d fn=%0d zero=%0d fw=%0d mw=%0d cycles=%0d", op, fn, z, fw, mw, q_st.size());
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [5:0] fn_pool [6];
        fn_pool = '{6'd32, 6'd34, 6'd24, 6'd26, 6'd8, 6'd42};
        bus.opcode = '0; bus.func = '0; bus.zero = 1'b0; bus.memReady = 1'b1;

        // Held in reset: everything low even with memReady high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_word("reset", 23'd0);
        end
        @(negedge clk);
        rst = 1'b1; bus.memReady = 1'b0;
        #1;
        check_word("release", exp_ctrl(0, 6'd0, 1'b0, 1'b0, 1'b0));

        // Directed steps
        run_instr(6'd35, 6'd0, 1'b0, 3, 1);       // lw, fetch waits, one mem wait
        run_instr(6'd4,  6'd0, 1'b1, 0, 0);       // beq taken
        run_instr(6'd4,  6'd0, 1'b0, 0, 0);       // beq not taken
        run_instr(6'd5,  6'd0, 1'b0, 0, 0);       // bne taken
        run_instr(6'd5,  6'd0, 1'b1, 0, 0);       // bne not taken
        run_instr(6'd3,  6'd0, 1'b0, 0, 0);       // jal
        run_instr(6'd2,  6'd0, 1'b0, 0, 0);       // j
        run_instr(6'd0,  6'd8, 1'b0, 0, 0);       // jr
        run_instr(6'd63, 6'd0, 1'b0, 0, 0);       // illegal
        run_instr(6'd0,  6'd24, 1'b0, 0, 0);      // mult
        run_instr(6'd0,  6'd26, 1'b0, 1, 0);      // div
        run_instr(6'd0,  6'd32, 1'b0, 0, 0);      // add
        run_instr(6'd8,  6'd0, 1'b0, 0, 0);       // addi
        run_instr(6'd10, 6'd0, 1'b0, 0, 0);       // slti
        run_instr(6'd15, 6'd0, 1'b0, 0, 0);       // lui
        run_instr(6'd43, 6'd0, 1'b0, 0, 2);       // sw
        run_instr(6'd43, 6'd0, 1'b0, 0, 20);      // sw timeout
        run_instr(6'd35, 6'd0, 1'b0, 0, 15);      // ready on the limit cycle: success
        run_instr(6'd35, 6'd0, 1'b0, 0, 16);      // lw timeout
        run_instr(6'd0,  6'd32, 1'b0, 0, 0);      // recovery

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            op = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 9))
                    0: op = 6'd0;  1: op = 6'd35; 2: op = 6'd43; 3: op = 6'd8;  4: op = 6'd10;
                    5: op = 6'd15; 6: op = 6'd4;  7: op = 6'd5;  8: op = 6'd2;  default: op = 6'd3;
                endcase
            end
            fn = (op == 6'd0) ? fn_pool[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3)));
        end

        // Reset asserted in the middle of EXEC
        @(negedge clk);
        bus.opcode = 6'd0; bus.func = 6'd32; bus.memReady = 1'b1; #1;
        check_word("midrst fetch", exp_ctrl(0, 6'd0, 1'b0, 1'b1, 1'b0));
        @(negedge clk); #1;
        check_word("midrst decode", exp_ctrl(1, 6'd0, 1'b0, 1'b1, 1'b0));
        @(negedge clk); #1;
        check_word("midrst exec", exp_ctrl(6, 6'd0, 1'b0, 1'b1, 1'b0));
        #1 rst = 1'b0;
        #1;
        check_word("midrst asserted", 23'd0);
        @(negedge clk);
        rst = 1'b1; bus.memReady = 1'b0; #1;
        check_word("midrst release", exp_ctrl(0, 6'd0, 1'b0, 1'b0, 1'b0));
        $display("midop reset done");
        run_instr(6'd35, 6'd0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
